// File: rtl/shift_unit_seq_if.sv
// Bus between the control side and the multi-cycle shift unit.
//   start    : request, sampled by the unit only while not busy
//   op       : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   data_in  : operand, captured on an accepted start
//   shamt    : shift amount, captured on an accepted start
//   data_out : result register
//   busy     : high while shifting
//   done     : one-cycle completion pulse
// The master modport belongs to the requester and the slave modport to the shift unit.
interface shift_unit_seq_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;

    modport master (
        output start, op, data_in, shamt,
        input  data_out, busy, done
    );

    modport slave (
        input  start, op, data_in, shamt,
        output data_out, busy, done
    );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit. It shifts a WIDTH-bit operand one position per clock by SLL, SRL,
// SRA or ROR. The result is held on data_out, and a one-cycle done pulse is given at the end.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : shift_unit_seq_if slave (start/op/data_in/shamt in, data_out/busy/done out)
// All outputs come from registered state. No input reaches an output combinationally.
module shift_unit_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    shift_unit_seq_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   count_q;
    logic [1:0]       op_q;

    // One-position step of the selected operation.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       o);
        logic [WIDTH-1:0] r;
        case (o)
            2'b00:   r = {d[WIDTH-2:0], 1'b0};
            2'b01:   r = {1'b0, d[WIDTH-1:1]};
            2'b10:   r = {d[WIDTH-1], d[WIDTH-1:1]};
            default: r = {d[0], d[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            data_q  <= '0;
            count_q <= '0;
            op_q    <= 2'b00;
        end else begin
            case (state_q)
                // Idle and Done both accept a request. Accepting in Done gives back-to-back issue.
                StIdle, StDone: begin
                    if (bus.start) begin
                        data_q  <= bus.data_in;
                        op_q    <= bus.op;
                        count_q <= bus.shamt;
                        state_q <= (bus.shamt != '0) ? StShift : StDone;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StShift: begin
                    data_q  <= shift_step(data_q, op_q);
                    count_q <= count_q - SHW'(1);
                    if (count_q == SHW'(1)) begin
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.data_out = data_q;
    assign bus.busy     = (state_q == StShift);
    assign bus.done     = (state_q == StDone);

endmodule
